// File: rtl/masked_seq_pkg.sv
// Shared types and constants for the masked gadget pipeline sequencer.
// Optional precharge build: define MASKED_SEQ_CLR_EN.
package masked_seq_pkg;

   localparam int ROUND_W    = 8;
   localparam int LAYERS_MIN = 1;
   localparam int LAYERS_MAX = 16;
   localparam int ROUNDS_MIN = 1;
   localparam int ROUNDS_MAX = 255;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_CLR  = 2'b01,
      ST_RUN  = 2'b10,
      ST_DONE = 2'b11
   } state_e;

   function automatic logic cfg_legal(input int layers, input int rounds);
      return (layers >= LAYERS_MIN) && (layers <= LAYERS_MAX) &&
             (rounds >= ROUNDS_MIN) && (rounds <= ROUNDS_MAX);
   endfunction

   function automatic logic round_is_last(input logic [ROUND_W-1:0] r, input int rounds);
      return r == ROUND_W'(rounds - 1);
   endfunction

endpackage

// File: rtl/masked_seq_ctrl_onehot_ring.sv
// One-hot layer pointer: bit k set means layer k is the next to be enabled.
// Wraps from the top layer back to layer 0 on its own, so a sweep needs no explicit reload.
module onehot_ring
   import masked_seq_pkg::*;
#(
   parameter int LAYERS = 4
) (
   input  logic              C,
   input  logic              R,
   input  logic              step,
   input  logic              clear,
   output logic [LAYERS-1:0] ring
);

   localparam logic [LAYERS-1:0] HOME = LAYERS'(1);

   logic [LAYERS-1:0] ring_q;
   logic [LAYERS-1:0] ring_d;

   // Rotate left by one; with a single layer the pointer simply stays put.
   always_comb begin
      ring_d = ring_q;
      if (clear) begin
         ring_d = HOME;
      end else if (step) begin
         ring_d = (ring_q << 1) | (ring_q >> (LAYERS - 1));
      end
   end

   always_ff @(posedge C or negedge R) begin
      if (!R) begin
         ring_q <= HOME;
      end else begin
         ring_q <= ring_d;
      end
   end

   assign ring = ring_q;

endmodule

// File: rtl/masked_seq_ctrl.sv
// Sequencer stepping masked-gadget register layers, one fresh randomness word per step.
// Define MASKED_SEQ_CLR_EN to add a one-cycle datapath precharge (clr) before each operation.
module masked_seq_ctrl
   import masked_seq_pkg::*;
#(
   parameter int LAYERS = 4,
   parameter int ROUNDS = 10
) (
   input  logic               C,
   input  logic               R,
   input  logic               start,
   input  logic               abort,
   input  logic               rnd_vld,
   output logic               rnd_take,
   output logic [LAYERS-1:0]  en,
   output logic               ld,
   output logic               fb,
`ifdef MASKED_SEQ_CLR_EN
   output logic               clr,
`endif
   output logic               busy,
   output logic               done,
   output logic [ROUND_W-1:0] round
);

   if (!cfg_legal(LAYERS, ROUNDS)) begin : g_cfg_check
      $error("masked_seq_ctrl: LAYERS or ROUNDS outside legal range");
   end

`ifdef MASKED_SEQ_CLR_EN
   localparam state_e ST_FIRST = ST_CLR;
`else
   localparam state_e ST_FIRST = ST_RUN;
`endif

   state_e               state_q, state_d;
   logic [ROUND_W-1:0]   round_q, round_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;

   logic [LAYERS-1:0]    ring;
   logic                 ring_step;
   logic                 ring_clear;
   logic                 fire;
   logic                 last_layer;
   logic                 last_round;
   logic                 in_op;

   onehot_ring #(
      .LAYERS (LAYERS)
   ) u_ring (
      .C     (C),
      .R     (R),
      .step  (ring_step),
      .clear (ring_clear),
      .ring  (ring)
   );

   // A layer step happens only in RUN with fresh randomness and no abort pending.
   assign in_op      = (state_q != ST_IDLE);
   assign fire       = (state_q == ST_RUN) && rnd_vld && !abort;
   assign last_layer = ring[LAYERS-1];
   assign last_round = round_is_last(round_q, ROUNDS);

   always_comb begin
      state_d    = state_q;
      round_d    = round_q;
      ring_step  = fire;
      ring_clear = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start && !abort) begin
               state_d    = ST_FIRST;
               round_d    = '0;
               ring_clear = 1'b1;
            end
         end
         ST_CLR: begin
            state_d = ST_RUN;
         end
         ST_RUN: begin
            if (fire && last_layer) begin
               if (last_round) begin
                  state_d = ST_DONE;
               end else begin
                  round_d = round_q + 1'b1;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
      endcase

      // Abort overrides everything outside IDLE and drops the round index.
      if (abort && in_op) begin
         state_d    = ST_IDLE;
         round_d    = '0;
         ring_clear = 1'b1;
      end

      busy_d = (state_d != ST_IDLE);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge C or negedge R) begin
      if (!R) begin
         state_q <= ST_IDLE;
         round_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         round_q <= round_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign en       = fire ? ring : '0;
   assign rnd_take = fire;
   assign ld       = fire && ring[0] && (round_q == '0);
   assign fb       = fire && ring[0] && (round_q != '0);
`ifdef MASKED_SEQ_CLR_EN
   assign clr      = (state_q == ST_CLR) && !abort;
`endif

   assign busy  = busy_q;
   assign done  = done_q;
   assign round = round_q;

endmodule
